// File: rtl/pyc_mem_pkg.sv
// Shared memory-port types for the pyc SRAM slice: master IDs, strobe-width
// derivation and the default request record.
package pyc_mem_pkg;

   typedef logic [0:0] mid_t;

   localparam int unsigned DEF_ADDR_WIDTH = 10;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   function automatic int unsigned strb_width(input int unsigned data_width);
      return (data_width + 7) / 8;
   endfunction

   localparam int unsigned DEF_STRB_WIDTH = strb_width(DEF_DATA_WIDTH);

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic                      write;
      logic [DEF_DATA_WIDTH-1:0] wdata;
      logic [DEF_STRB_WIDTH-1:0] wstrb;
   } mem_req_t;

endpackage

// File: rtl/pyc_id_fifo.sv
// Small synchronous FIFO holding the owner ID of each in-flight request.
// Pushes while full and pops while empty are ignored.
module pyc_id_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pyc_sram_arb2.sv
// Two-master round-robin arbiter in front of the single-port SRAM; an owner
// FIFO steers each in-order response back to the master that issued it.
module pyc_sram_arb2
   import pyc_mem_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH      = 10,
   parameter  int unsigned DATA_WIDTH      = 32,
   parameter  int unsigned MAX_OUTSTANDING = 2,
   localparam int unsigned STRB_WIDTH      = strb_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic [ADDR_WIDTH-1:0] m0_req_addr,
   input  logic                  m0_req_write,
   input  logic [DATA_WIDTH-1:0] m0_req_wdata,
   input  logic [STRB_WIDTH-1:0] m0_req_wstrb,
   output logic                  m0_resp_valid,
   input  logic                  m0_resp_ready,
   output logic [DATA_WIDTH-1:0] m0_resp_rdata,

   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic [ADDR_WIDTH-1:0] m1_req_addr,
   input  logic                  m1_req_write,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata,
   input  logic [STRB_WIDTH-1:0] m1_req_wstrb,
   output logic                  m1_resp_valid,
   input  logic                  m1_resp_ready,
   output logic [DATA_WIDTH-1:0] m1_resp_rdata,

   output logic                  s_req_valid,
   input  logic                  s_req_ready,
   output logic [ADDR_WIDTH-1:0] s_req_addr,
   output logic                  s_req_write,
   output logic [DATA_WIDTH-1:0] s_req_wdata,
   output logic [STRB_WIDTH-1:0] s_req_wstrb,
   input  logic                  s_resp_valid,
   output logic                  s_resp_ready,
   input  logic [DATA_WIDTH-1:0] s_resp_rdata,

   output logic                  err
);

   mid_t last_grant;
   mid_t lock_id;
   mid_t grant;
   mid_t head;
   logic lock;
   logic full;
   logic empty;
   logic req_fire;
   logic resp_fire;

   // A stalled request keeps its grant so the SRAM sees a stable payload.
   always_comb begin
      if (lock) begin
         grant = lock_id;
      end else if (m0_req_valid && !m1_req_valid) begin
         grant = 1'b0;
      end else if (m1_req_valid && !m0_req_valid) begin
         grant = 1'b1;
      end else begin
         grant = ~last_grant;
      end
   end

   always_comb begin
      if (grant == 1'b1) begin
         s_req_valid = m1_req_valid && !full;
         s_req_addr  = m1_req_addr;
         s_req_write = m1_req_write;
         s_req_wdata = m1_req_wdata;
         s_req_wstrb = m1_req_wstrb;
      end else begin
         s_req_valid = m0_req_valid && !full;
         s_req_addr  = m0_req_addr;
         s_req_write = m0_req_write;
         s_req_wdata = m0_req_wdata;
         s_req_wstrb = m0_req_wstrb;
      end
   end

   assign m0_req_ready = (grant == 1'b0) && s_req_ready && !full;
   assign m1_req_ready = (grant == 1'b1) && s_req_ready && !full;
   assign req_fire     = s_req_valid && s_req_ready;

   // With nothing outstanding, responses are stray and drained unconditionally.
   always_comb begin
      if (empty) begin
         s_resp_ready = 1'b1;
      end else if (head == 1'b1) begin
         s_resp_ready = m1_resp_ready;
      end else begin
         s_resp_ready = m0_resp_ready;
      end
   end

   assign m0_resp_valid = s_resp_valid && !empty && (head == 1'b0);
   assign m1_resp_valid = s_resp_valid && !empty && (head == 1'b1);
   assign m0_resp_rdata = s_resp_rdata;
   assign m1_resp_rdata = s_resp_rdata;
   assign resp_fire     = s_resp_valid && s_resp_ready && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         lock       <= 1'b0;
         lock_id    <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (req_fire) begin
            last_grant <= grant;
            lock       <= 1'b0;
         end else if (s_req_valid) begin
            lock       <= 1'b1;
            lock_id    <= grant;
         end
         if (s_resp_valid && empty) begin
            err <= 1'b1;
         end
      end
   end

   pyc_id_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (req_fire),
      .push_data (grant),
      .pop       (resp_fire),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_pyc_sram_arb2.sv
// Self-checking bench for pyc_sram_arb2 with a one-cycle SRAM model and an
// in-order response scoreboard keyed by requesting master.
module tb_pyc_sram_arb2;

   logic        clk;
   logic        rst_n;

   logic        m0_req_valid, m0_req_ready, m0_req_write;
   logic [9:0]  m0_req_addr;
   logic [31:0] m0_req_wdata;
   logic [3:0]  m0_req_wstrb;
   logic        m0_resp_valid, m0_resp_ready;
   logic [31:0] m0_resp_rdata;

   logic        m1_req_valid, m1_req_ready, m1_req_write;
   logic [9:0]  m1_req_addr;
   logic [31:0] m1_req_wdata;
   logic [3:0]  m1_req_wstrb;
   logic        m1_resp_valid, m1_resp_ready;
   logic [31:0] m1_resp_rdata;

   logic        s_req_valid, s_req_ready, s_req_write;
   logic [9:0]  s_req_addr;
   logic [31:0] s_req_wdata;
   logic [3:0]  s_req_wstrb;
   logic        s_resp_valid, s_resp_ready;
   logic [31:0] s_resp_rdata;
   logic        err;

   // SRAM model controls and state
   logic        sram_stall  = 1'b0;
   logic        resp_hold   = 1'b0;
   logic        inject_stray = 1'b0;
   logic        pend_valid  = 1'b0;
   logic [31:0] pend_data   = 32'h0;
   logic [31:0] rq [$];
   logic [31:0] mem [int unsigned];

   typedef struct {
      logic        id;
      logic [31:0] data;
   } exp_t;
   exp_t sb [$];

   typedef struct {
      logic       v0, v1, sr;
      logic       r0, r1, sv;
      logic [9:0] addr;
   } vec_t;
   vec_t vt [13];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          resp_cnt [2];
   logic [31:0] last_rdata [2];

   assign s_req_ready  = !sram_stall;
   assign s_resp_valid = inject_stray || (pend_valid && !resp_hold);
   assign s_resp_rdata = pend_data;

   pyc_sram_arb2 #(
      .ADDR_WIDTH      (10),
      .DATA_WIDTH      (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m0_req_valid  (m0_req_valid),
      .m0_req_ready  (m0_req_ready),
      .m0_req_addr   (m0_req_addr),
      .m0_req_write  (m0_req_write),
      .m0_req_wdata  (m0_req_wdata),
      .m0_req_wstrb  (m0_req_wstrb),
      .m0_resp_valid (m0_resp_valid),
      .m0_resp_ready (m0_resp_ready),
      .m0_resp_rdata (m0_resp_rdata),
      .m1_req_valid  (m1_req_valid),
      .m1_req_ready  (m1_req_ready),
      .m1_req_addr   (m1_req_addr),
      .m1_req_write  (m1_req_write),
      .m1_req_wdata  (m1_req_wdata),
      .m1_req_wstrb  (m1_req_wstrb),
      .m1_resp_valid (m1_resp_valid),
      .m1_resp_ready (m1_resp_ready),
      .m1_resp_rdata (m1_resp_rdata),
      .s_req_valid   (s_req_valid),
      .s_req_ready   (s_req_ready),
      .s_req_addr    (s_req_addr),
      .s_req_write   (s_req_write),
      .s_req_wdata   (s_req_wdata),
      .s_req_wstrb   (s_req_wstrb),
      .s_resp_valid  (s_resp_valid),
      .s_resp_ready  (s_resp_ready),
      .s_resp_rdata  (s_resp_rdata),
      .err           (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b, required %0b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v0, input logic v1, input logic sr,
                               input logic r0, input logic r1, input logic sv,
                               input logic [9:0] addr);
      vec_t v;
      v.v0 = v0; v.v1 = v1; v.sr = sr;
      v.r0 = r0; v.r1 = r1; v.sv = sv;
      v.addr = addr;
      return v;
   endfunction

   // Samples 1 time unit before each rising edge; updates the SRAM model 1 after it.
   always begin : monitor
      logic        snap_req, snap_rsp, snap_wr, id;
      logic [9:0]  snap_addr;
      logic [31:0] snap_wdata, snap_old, data, nw;
      logic [3:0]  snap_strb;
      exp_t        e;
      @(negedge clk);
      #4;
      snap_req = 1'b0;
      snap_rsp = 1'b0;
      snap_wr  = 1'b0;
      snap_addr = '0; snap_wdata = '0; snap_strb = '0; snap_old = '0;
      if (rst_n) begin
         if (m0_resp_valid || m1_resp_valid) begin
            n_cmp++;
            if ((m0_resp_valid && m1_resp_valid) || sb.size() == 0 || sb[0].id != m1_resp_valid) begin
               n_bad++;
               $display("FAIL resp_steer: m0_resp_valid=%0b m1_resp_valid=%0b, required valid only for owner (pending=%0d)",
                        m0_resp_valid, m1_resp_valid, sb.size());
            end
         end
         if ((m0_resp_valid && m0_resp_ready) || (m1_resp_valid && m1_resp_ready)) begin
            id   = m1_resp_valid && m1_resp_ready;
            data = id ? m1_resp_rdata : m0_resp_rdata;
            last_rdata[id] = data;
            resp_cnt[id]++;
            if (sb.size() != 0) begin
               e = sb.pop_front();
               n_cmp++;
               if (e.id != id || e.data != data) begin
                  n_bad++;
                  $display("FAIL resp_data: got m%0d 0x%08h, required m%0d 0x%08h", id, data, e.id, e.data);
               end
            end
         end
         if (s_req_valid && s_req_ready) begin
            id = m1_req_valid && m1_req_ready;
            n_cmp++;
            if (((m0_req_valid && m0_req_ready) == (m1_req_valid && m1_req_ready)) ||
                s_req_addr  != (id ? m1_req_addr  : m0_req_addr)  ||
                s_req_write != (id ? m1_req_write : m0_req_write) ||
                s_req_wdata != (id ? m1_req_wdata : m0_req_wdata) ||
                s_req_wstrb != (id ? m1_req_wstrb : m0_req_wstrb)) begin
               n_bad++;
               $display("FAIL req_payload: got addr 0x%03h r0=%0b r1=%0b, required single granted master payload",
                        s_req_addr, m0_req_ready, m1_req_ready);
            end
            snap_req   = 1'b1;
            snap_wr    = s_req_write;
            snap_addr  = s_req_addr;
            snap_wdata = s_req_wdata;
            snap_strb  = s_req_wstrb;
            snap_old   = mem.exists(int'(s_req_addr)) ? mem[int'(s_req_addr)] : 32'h0;
            e.id   = id;
            e.data = s_req_write ? 32'h0 : snap_old;
            sb.push_back(e);
         end
         snap_rsp = s_resp_valid && s_resp_ready && pend_valid && !inject_stray;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         rq.delete();
         sb.delete();
      end else begin
         if (snap_rsp) rq.delete(0);
         if (snap_req) begin
            if (snap_wr) begin
               nw = snap_old;
               for (int b = 0; b < 4; b++) begin
                  if (snap_strb[b]) nw[b*8 +: 8] = snap_wdata[b*8 +: 8];
               end
               mem[int'(snap_addr)] = nw;
            end
            rq.push_back(snap_wr ? 32'h0 : snap_old);
         end
      end
      pend_valid = (rq.size() != 0);
      pend_data  = pend_valid ? rq[0] : 32'h0;
   end

   task automatic do_req(input logic id, input logic [9:0] a, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st);
      int unsigned n;
      @(negedge clk);
      if (id) begin
         m1_req_valid = 1'b1; m1_req_addr = a; m1_req_write = wr; m1_req_wdata = wd; m1_req_wstrb = st;
      end else begin
         m0_req_valid = 1'b1; m0_req_addr = a; m0_req_write = wr; m0_req_wdata = wd; m0_req_wstrb = st;
      end
      n = 0;
      forever begin
         #2;
         if (id ? m1_req_ready : m0_req_ready) break;
         n++;
         if (n > 20) begin
            n_cmp++; n_bad++;
            $display("FAIL req_timeout: m%0d not accepted in 20 cycles, required acceptance", id);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      if (id) m1_req_valid = 1'b0;
      else    m0_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n;
      n = 0;
      while (sb.size() != 0 || pend_valid) begin
         @(negedge clk);
         n++;
         if (n > 30) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", sb.size());
            break;
         end
      end
   endtask

   initial begin : stim
      int base0;
      rst_n = 1'b0;
      m0_req_valid = 1'b0; m0_req_addr = 10'h010; m0_req_write = 1'b0; m0_req_wdata = '0; m0_req_wstrb = '0;
      m1_req_valid = 1'b0; m1_req_addr = 10'h020; m1_req_write = 1'b0; m1_req_wdata = '0; m1_req_wstrb = '0;
      m0_resp_ready = 1'b1;
      m1_resp_ready = 1'b1;
      resp_cnt[0] = 0; resp_cnt[1] = 0;
      last_rdata[0] = '0; last_rdata[1] = '0;

      vt[0]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010);
      vt[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020);
      vt[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010);
      vt[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020);
      vt[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010);
      vt[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020);
      vt[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020);
      vt[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020);
      vt[8]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010);
      vt[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020);
      vt[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020);
      vt[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'h020);
      vt[12] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h010);

      // Reset state
      repeat (2) @(negedge clk);
      #2;
      chk1("rst_m0_resp_valid", m0_resp_valid, 1'b0);
      chk1("rst_m1_resp_valid", m1_resp_valid, 1'b0);
      chk1("rst_s_resp_ready", s_resp_ready, 1'b1);
      chk1("rst_s_req_valid", s_req_valid, 1'b0);
      chk1("rst_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Grant table: alternation, single requesters, lock under stall
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         m0_req_valid = vt[i].v0;
         m1_req_valid = vt[i].v1;
         sram_stall   = !vt[i].sr;
         #2;
         chk1($sformatf("tbl%0d_r0", i), m0_req_ready, vt[i].r0);
         chk1($sformatf("tbl%0d_r1", i), m1_req_ready, vt[i].r1);
         chk1($sformatf("tbl%0d_sv", i), s_req_valid, vt[i].sv);
         chkw($sformatf("tbl%0d_addr", i), 32'(s_req_addr), 32'(vt[i].addr));
      end
      @(negedge clk);
      m0_req_valid = 1'b0;
      m1_req_valid = 1'b0;
      sram_stall   = 1'b0;
      wait_drain();

      // Write by m0 then read-back by m1
      base0 = resp_cnt[0];
      do_req(1'b0, 10'd5, 1'b1, 32'hDEADBEEF, 4'hF);
      do_req(1'b1, 10'd5, 1'b0, 32'h0, 4'h0);
      wait_drain();
      chkw("a_m1_rdata", last_rdata[1], 32'hDEADBEEF);
      chkw("a_m0_resp_cnt", 32'(resp_cnt[0] - base0), 32'd1);

      // SRAM stalls while m0 is presented; m1 must wait for m0 to fire
      @(negedge clk);
      sram_stall = 1'b1;
      m0_req_valid = 1'b1; m0_req_addr = 10'h033; m0_req_write = 1'b0;
      @(negedge clk);
      m1_req_valid = 1'b1; m1_req_addr = 10'h044; m1_req_write = 1'b0;
      repeat (3) begin
         #2;
         chkw("b_addr_held", 32'(s_req_addr), 32'h033);
         chk1("b_m1_ready", m1_req_ready, 1'b0);
         chk1("b_m0_ready", m0_req_ready, 1'b0);
         @(negedge clk);
      end
      sram_stall = 1'b0;
      #2;
      chk1("b_m0_fire", m0_req_ready, 1'b1);
      @(negedge clk);
      m0_req_valid = 1'b0;
      #2;
      chk1("b_m1_next", m1_req_ready, 1'b1);
      chkw("b_m1_addr", 32'(s_req_addr), 32'h044);
      @(negedge clk);
      m1_req_valid = 1'b0;
      wait_drain();

      // Owner FIFO full: third request waits until a response pops
      resp_hold = 1'b1;
      @(negedge clk);
      m0_req_valid = 1'b1; m0_req_addr = 10'h001;
      #2;
      chk1("c_r0_first", m0_req_ready, 1'b1);
      @(negedge clk);
      m0_req_addr = 10'h002;
      #2;
      chk1("c_r0_second", m0_req_ready, 1'b1);
      @(negedge clk);
      m0_req_addr = 10'h003;
      m1_req_valid = 1'b1; m1_req_addr = 10'h004;
      repeat (2) begin
         #2;
         chk1("c_full_r0", m0_req_ready, 1'b0);
         chk1("c_full_r1", m1_req_ready, 1'b0);
         chk1("c_full_sv", s_req_valid, 1'b0);
         @(negedge clk);
      end
      resp_hold = 1'b0;
      #2;
      chk1("c_pop_cycle_r0", m0_req_ready, 1'b0);
      chk1("c_pop_cycle_r1", m1_req_ready, 1'b0);
      @(negedge clk);
      #2;
      chk1("c_after_pop_sv", s_req_valid, 1'b1);
      chk1("c_after_pop_r1", m1_req_ready, 1'b1);
      @(negedge clk);
      m1_req_valid = 1'b0;
      #2;
      chk1("c_m0_resume", m0_req_ready, 1'b1);
      @(negedge clk);
      m0_req_valid = 1'b0;
      wait_drain();

      // m1 back-pressures its response; m0's later response must wait
      m1_resp_ready = 1'b0;
      @(negedge clk);
      m1_req_valid = 1'b1; m1_req_addr = 10'd5; m1_req_write = 1'b0;
      #2;
      chk1("d_r1", m1_req_ready, 1'b1);
      @(negedge clk);
      m1_req_valid = 1'b0;
      m0_req_valid = 1'b1; m0_req_addr = 10'h010; m0_req_write = 1'b0;
      #2;
      chk1("d_r0", m0_req_ready, 1'b1);
      @(negedge clk);
      m0_req_valid = 1'b0;
      repeat (4) begin
         #2;
         chk1("d_s_resp_ready", s_resp_ready, 1'b0);
         chk1("d_m1_resp_valid", m1_resp_valid, 1'b1);
         chk1("d_m0_resp_valid", m0_resp_valid, 1'b0);
         chkw("d_m1_rdata", m1_resp_rdata, 32'hDEADBEEF);
         @(negedge clk);
      end
      m1_resp_ready = 1'b1;
      #2;
      chk1("d_release_s_ready", s_resp_ready, 1'b1);
      @(negedge clk);
      #2;
      chk1("d_m0_next", m0_resp_valid, 1'b1);
      wait_drain();

      // Stray response sets sticky err; async reset clears it
      #2;
      chk1("e_err_pre", err, 1'b0);
      @(negedge clk);
      inject_stray = 1'b1;
      #2;
      chk1("e_s_resp_ready", s_resp_ready, 1'b1);
      chk1("e_m0_resp_valid", m0_resp_valid, 1'b0);
      chk1("e_m1_resp_valid", m1_resp_valid, 1'b0);
      @(negedge clk);
      inject_stray = 1'b0;
      #2;
      chk1("e_err_set", err, 1'b1);
      repeat (3) @(negedge clk);
      #2;
      chk1("e_err_sticky", err, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("e_err_async_clear", err, 1'b0);
      chk1("e_rst_s_resp_ready", s_resp_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
